// File: rtl/rps_match_controller.sv
// Best-of-N stone/paper/scissors match sequencer: collects both moves, drives the judge, tallies rounds.
// Optional macro RPS_TIMEOUT_EN: COLLECT timeout that forces a round result without calling the judge.
module rps_match_controller #(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 7,
    parameter int SCORE_W       = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               new_match,
    input  logic               p1_valid,
    input  logic [1:0]         p1_move,
    output logic               p1_ready,
    input  logic               p2_valid,
    input  logic [1:0]         p2_move,
    output logic               p2_ready,
    output logic               judge_start,
    output logic [1:0]         judge_p1,
    output logic [1:0]         judge_p2,
    input  logic               judge_done,
    input  logic [1:0]         judge_result,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] round_cnt,
    output logic               match_over,
    output logic [1:0]         match_winner
);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_JUDGE, S_WAIT, S_SCORE, S_DONE} state_t;

    state_t             state;
    logic               cap1, cap2;
    logic [1:0]         res;
    logic               fire1, fire2, got1, got2;
    logic [SCORE_W-1:0] s1_nxt, s2_nxt, rc_nxt;
    logic               end_match;
    logic [1:0]         win_nxt;

`ifdef RPS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign p1_ready    = ena && (state == S_COLLECT) && !cap1;
    assign p2_ready    = ena && (state == S_COLLECT) && !cap2;
    assign judge_start = ena && (state == S_JUDGE);
    assign fire1       = p1_valid && p1_ready;
    assign fire2       = p2_valid && p2_ready;
    assign got1        = cap1 || fire1;
    assign got2        = cap2 || fire2;

    // Score update for the SCORE cycle; result 11 replays the round untouched.
    always_comb begin
        s1_nxt = score1;
        s2_nxt = score2;
        rc_nxt = round_cnt;
        case (res)
            2'b01: begin s1_nxt = score1 + 1'b1; rc_nxt = round_cnt + 1'b1; end
            2'b10: begin s2_nxt = score2 + 1'b1; rc_nxt = round_cnt + 1'b1; end
            2'b00: rc_nxt = round_cnt + 1'b1;
            default: ;
        endcase
        end_match = (s1_nxt == SCORE_W'(ROUNDS_TO_WIN)) || (s2_nxt == SCORE_W'(ROUNDS_TO_WIN)) ||
                    (rc_nxt == SCORE_W'(MAX_ROUNDS));
        win_nxt   = (s1_nxt > s2_nxt) ? 2'b01 : (s2_nxt > s1_nxt) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cap1         <= 1'b0;
            cap2         <= 1'b0;
            res          <= 2'b00;
            judge_p1     <= 2'b00;
            judge_p2     <= 2'b00;
            score1       <= '0;
            score2       <= '0;
            round_cnt    <= '0;
            match_over   <= 1'b0;
            match_winner <= 2'b00;
`ifdef RPS_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else if (ena) begin
            if (new_match) begin
                // Restart wins over any capture or judge completion in the same cycle.
                state        <= S_COLLECT;
                cap1         <= 1'b0;
                cap2         <= 1'b0;
                res          <= 2'b00;
                judge_p1     <= 2'b00;
                judge_p2     <= 2'b00;
                score1       <= '0;
                score2       <= '0;
                round_cnt    <= '0;
                match_over   <= 1'b0;
                match_winner <= 2'b00;
`ifdef RPS_TIMEOUT_EN
                tmo_cnt      <= '0;
`endif
            end else begin
                case (state)
                    S_COLLECT: begin
                        if (fire1) begin cap1 <= 1'b1; judge_p1 <= p1_move; end
                        if (fire2) begin cap2 <= 1'b1; judge_p2 <= p2_move; end
                        if (got1 && got2) state <= S_JUDGE;
`ifdef RPS_TIMEOUT_EN
                        else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                            res   <= {got2 && !got1, got1 && !got2};
                            state <= S_SCORE;
                        end else tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                    S_JUDGE: state <= S_WAIT;
                    S_WAIT: if (judge_done) begin
                        res   <= judge_result;
                        state <= S_SCORE;
                    end
                    S_SCORE: begin
                        score1    <= s1_nxt;
                        score2    <= s2_nxt;
                        round_cnt <= rc_nxt;
                        cap1      <= 1'b0;
                        cap2      <= 1'b0;
                        if (end_match) begin
                            state        <= S_DONE;
                            match_over   <= 1'b1;
                            match_winner <= win_nxt;
                        end else begin
                            state <= S_COLLECT;
`ifdef RPS_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rps_match_controller.sv
// Scoreboard bench for rps_match_controller: expected moves/scores queued at stimulus, checked at DUT output.
module tb_rps_match_controller;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, new_match = 1'b0;
    logic       p1_valid = 1'b0, p2_valid = 1'b0, judge_done = 1'b0;
    logic [1:0] p1_move = 2'b00, p2_move = 2'b00, judge_result = 2'b00;
    logic       p1_ready, p2_ready, judge_start, match_over;
    logic [1:0] judge_p1, judge_p2, match_winner;
    logic [3:0] score1, score2, round_cnt;

    rps_match_controller #(.ROUNDS_TO_WIN(2), .MAX_ROUNDS(7), .SCORE_W(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .new_match(new_match),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .judge_start(judge_start), .judge_p1(judge_p1), .judge_p2(judge_p2),
        .judge_done(judge_done), .judge_result(judge_result),
        .score1(score1), .score2(score2), .round_cnt(round_cnt),
        .match_over(match_over), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s1, s2, rc;
        logic       ov;
        logic [1:0] w;
    } exp_t;

    int         checks = 0, errors = 0;
    int         e1, e2, erc;
    logic [3:0] mv_q[$];
    exp_t       sc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference tally: push the expected post-SCORE state for the result just driven.
    task automatic model(input logic [1:0] r);
        exp_t e;
        case (r)
            2'b01: begin e1++; erc++; end
            2'b10: begin e2++; erc++; end
            2'b00: erc++;
            default: ;
        endcase
        e.s1 = 4'(e1);
        e.s2 = 4'(e2);
        e.rc = 4'(erc);
        e.ov = (e1 == 2) || (e2 == 2) || (erc == 7);
        e.w  = !e.ov ? 2'b00 : (e1 > e2) ? 2'b01 : (e2 > e1) ? 2'b10 : 2'b00;
        sc_q.push_back(e);
    endtask

    task automatic check_score(input string tag);
        exp_t e;
        if (sc_q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
            return;
        end
        e = sc_q.pop_front();
        chk({tag, "_score1"}, score1, e.s1);
        chk({tag, "_score2"}, score2, e.s2);
        chk({tag, "_round_cnt"}, round_cnt, e.rc);
        chk({tag, "_over"}, match_over, e.ov);
        chk({tag, "_winner"}, match_winner, e.w);
    endtask

    task automatic start_match();
        @(negedge clk) new_match = 1'b1;
        @(negedge clk) new_match = 1'b0;
        e1 = 0; e2 = 0; erc = 0;
        mv_q.delete();
        sc_q.delete();
    endtask

    // Drive both moves, wait for judge_start, hold the judge busy for lat cycles, then answer r.
    task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] r,
                              input int lat, input string tag);
        int t;
        logic [3:0] mv;
        @(negedge clk);
        p1_valid = 1'b1; p2_valid = 1'b1; p1_move = m1; p2_move = m2;
        mv_q.push_back({m1, m2});
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        t = 0;
        while (!judge_start && t < 20) begin @(negedge clk); t++; end
        mv = mv_q.pop_front();
        if (!judge_start) begin
            chk({tag, "_start_seen"}, 0, 1);
            return;
        end
        chk({tag, "_ready_drop"}, {p1_ready, p2_ready}, 2'b00);
        chk({tag, "_judge_moves"}, {judge_p1, judge_p2}, mv);
        repeat (lat) begin
            @(negedge clk);
            chk({tag, "_moves_stable"}, {judge_p1, judge_p2}, mv);
            chk({tag, "_single_start"}, judge_start, 0);
        end
        judge_done = 1'b1; judge_result = r;
        model(r);
        @(negedge clk) judge_done = 1'b0;
        @(negedge clk);
        check_score(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset values
        #2;
        chk("rst_score1", score1, 0);
        chk("rst_round_cnt", round_cnt, 0);
        chk("rst_over", match_over, 0);
        chk("rst_ready", {p1_ready, p2_ready, judge_start}, 0);
        chk("rst_judge_moves", {judge_p1, judge_p2}, 0);
        @(negedge clk) rst_n = 1'b1; ena = 1'b1;
        @(negedge clk);
        chk("idle_ready", {p1_ready, p2_ready}, 0);

        // Two p1 wins take the match
        start_match();
        chk("collect_ready", {p1_ready, p2_ready}, 2'b11);
        play_round(2'b00, 2'b10, 2'b01, 1, "t1_r1");
        play_round(2'b00, 2'b10, 2'b01, 1, "t1_r2");
        chk("t1_done_ready", {p1_ready, p2_ready}, 0);

        // Simultaneous capture, slow judge, invalid-move replay, staggered capture
        start_match();
        play_round(2'b01, 2'b00, 2'b01, 5, "t2");
        play_round(2'b00, 2'b11, 2'b11, 2, "t3");
        chk("t3_ready", {p1_ready, p2_ready}, 2'b11);
        @(negedge clk) p1_valid = 1'b1; p1_move = 2'b10;
        @(negedge clk);
        chk("stag_ready", {p1_ready, p2_ready}, 2'b01);
        p1_move = 2'b00;
        @(negedge clk) p1_valid = 1'b0; p2_valid = 1'b1; p2_move = 2'b01;
        @(negedge clk) p2_valid = 1'b0;
        chk("stag_start", judge_start, 1);
        chk("stag_moves", {judge_p1, judge_p2}, 4'b1001);
        @(negedge clk) judge_done = 1'b1; judge_result = 2'b10;
        model(2'b10);
        @(negedge clk) judge_done = 1'b0;
        @(negedge clk);
        check_score("stag");
        // judge_done in COLLECT must be ignored
        judge_done = 1'b1; judge_result = 2'b01;
        @(negedge clk) judge_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_done_score1", score1, 1);
        chk("stray_done_round", round_cnt, 2);
        // ena low freezes: readies drop and an offered move is not taken
        ena = 1'b0; p1_valid = 1'b1; p1_move = 2'b01;
        #1 chk("ena_ready", {p1_ready, p2_ready}, 0);
        @(negedge clk) p1_valid = 1'b0; ena = 1'b1;
        #1 chk("ena_no_capture", {p1_ready, judge_p1}, {1'b1, 2'b10});

        // Seven ties force the match over as a draw
        start_match();
        for (int i = 0; i < 7; i++) play_round(2'b01, 2'b01, 2'b00, 1, $sformatf("t4_r%0d", i));

        // new_match beats a simultaneous judge_done
        start_match();
        play_round(2'b00, 2'b10, 2'b01, 1, "t5_r1");
        @(negedge clk) p1_valid = 1'b1; p2_valid = 1'b1; p1_move = 2'b01; p2_move = 2'b10;
        @(negedge clk) p1_valid = 1'b0; p2_valid = 1'b0;
        t = 0;
        while (!judge_start && t < 20) begin @(negedge clk); t++; end
        chk("t5_start", judge_start, 1);
        @(negedge clk) judge_done = 1'b1; judge_result = 2'b01; new_match = 1'b1;
        @(negedge clk) judge_done = 1'b0; new_match = 1'b0;
        chk("t5_scores", {score1, score2, round_cnt}, 0);
        chk("t5_collect", {p1_ready, p2_ready}, 2'b11);
        chk("t5_judge_moves", {judge_p1, judge_p2}, 0);
        e1 = 0; e2 = 0; erc = 0;
        // Asynchronous reset mid-match
        play_round(2'b10, 2'b00, 2'b10, 1, "t5_r2");
        @(negedge clk) p1_valid = 1'b1; p1_move = 2'b01;
        @(negedge clk) p1_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_scores", {score1, score2, round_cnt}, 0);
        chk("arst_outs", {p1_ready, p2_ready, judge_start, match_over, match_winner, judge_p1, judge_p2}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", {p1_ready, p2_ready}, 0);

`ifdef RPS_TIMEOUT_EN
        // Only p2 submits; timeout forces a p2 round win, ena-low cycles do not count
        begin
            int starts;
            starts = 0;
            start_match();
            p2_valid = 1'b1; p2_move = 2'b01;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if (judge_start) starts++;
                if (n == 1) p2_valid = 1'b0;
                if (n == 4) begin
                    ena = 1'b0;
                    repeat (3) @(negedge clk);
                    chk("tmo_ena_ready", p1_ready, 0);
                    ena = 1'b1;
                end
            end
            chk("tmo_not_yet", score2, 0);
            @(negedge clk);
            if (judge_start) starts++;
            chk("tmo_score2", score2, 1);
            chk("tmo_round", round_cnt, 1);
            chk("tmo_no_start", starts, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
